// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel coordinates, VGA sync/blanking, line/frame markers and frame count.
// Every output is a flop loaded from the decode of the next scan position.
module vga_scan_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_pix_en,
  output logic [9:0] o_x_cord,
  output logic [9:0] o_y_cord,
  output logic       o_hsync_n,
  output logic       o_vsync_n,
  output logic       o_active,
  output logic       o_line_start,
  output logic       o_frame_start,
  output logic [7:0] o_frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_timing_check
    $error("vga_scan_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0]  XLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  YLast   = 10'(V_TOTAL - 1);
  // 11-bit bounds so a sync window ending exactly at 1024 does not truncate
  localparam logic [10:0] HAct    = 11'(H_ACTIVE);
  localparam logic [10:0] HsStart = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HsEnd   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VAct    = 11'(V_ACTIVE);
  localparam logic [10:0] VsStart = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VsEnd   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [7:0] cnt_q, cnt_d;
  logic       started_q, started_d;
  logic       hsync_n_q, hsync_n_d;
  logic       vsync_n_q, vsync_n_d;
  logic       active_q, active_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [10:0] x_ext, y_ext;

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    started_d = started_q;
    if (i_pix_en) begin
      if (x_q == XLast) begin
        x_d = '0;
        if (y_q == YLast) begin
          y_d = '0;
          // The wrap out of reset enters frame 0 and is not a completed frame
          if (started_q) begin
            cnt_d = cnt_q + 8'd1;
          end
          started_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  always_comb begin
    x_ext         = {1'b0, x_d};
    y_ext         = {1'b0, y_d};
    active_d      = (x_ext < HAct) && (y_ext < VAct);
    hsync_n_d     = !((x_ext >= HsStart) && (x_ext < HsEnd));
    vsync_n_d     = !((y_ext >= VsStart) && (y_ext < VsEnd));
    line_start_d  = (x_d == 10'd0);
    frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= XLast;
      y_q           <= YLast;
      cnt_q         <= '0;
      started_q     <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      cnt_q         <= cnt_d;
      started_q     <= started_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_x_cord      = x_q;
  assign o_y_cord      = y_q;
  assign o_hsync_n     = hsync_n_q;
  assign o_vsync_n     = vsync_n_q;
  assign o_active      = active_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
  assign o_frame_cnt   = cnt_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a default 640x480 instance and a tiny-timing instance for full-frame runs.
// Expected outputs come from a linear pixel-index model of the scan.
module tb_vga_scan_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic pen_a, pen_b;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_hs, a_vs, a_act, a_ls, a_fs;
  logic       b_hs, b_vs, b_act, b_ls, b_fs;
  logic [7:0] a_cnt, b_cnt;
  logic [32:0] va, vb;

  int nvec  = 0;
  int nfail = 0;

  // Model state: linear pixel index within the frame and number of entries into (0,0)
  longint pos_a, ent_a, pos_b, ent_b;

  always #5 clk = ~clk;

  vga_scan_gen u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_pix_en     (pen_a),
    .o_x_cord     (a_x),
    .o_y_cord     (a_y),
    .o_hsync_n    (a_hs),
    .o_vsync_n    (a_vs),
    .o_active     (a_act),
    .o_line_start (a_ls),
    .o_frame_start(a_fs),
    .o_frame_cnt  (a_cnt)
  );

  vga_scan_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_pix_en     (pen_b),
    .o_x_cord     (b_x),
    .o_y_cord     (b_y),
    .o_hsync_n    (b_hs),
    .o_vsync_n    (b_vs),
    .o_active     (b_act),
    .o_line_start (b_ls),
    .o_frame_start(b_fs),
    .o_frame_cnt  (b_cnt)
  );

  assign va = {a_x, a_y, a_hs, a_vs, a_act, a_ls, a_fs, a_cnt};
  assign vb = {b_x, b_y, b_hs, b_vs, b_act, b_ls, b_fs, b_cnt};

  function automatic logic [32:0] model_vec(input int ha, input int hfp, input int hs,
                                            input int hbp, input int vact, input int vfp,
                                            input int vs, input longint pos, input longint ent);
    int ht, x, y;
    logic [7:0] fc;
    ht = ha + hfp + hs + hbp;
    x  = int'(pos % ht);
    y  = int'(pos / ht);
    fc = (ent == 0) ? 8'd0 : 8'((ent - 1) % 256);
    return {10'(x), 10'(y),
            !(x >= ha + hfp && x < ha + hfp + hs),
            !(y >= vact + vfp && y < vact + vfp + vs),
            (x < ha && y < vact), (x == 0), (x == 0 && y == 0), fc};
  endfunction

  function automatic logic [32:0] exp_a();
    return model_vec(640, 16, 96, 48, 480, 10, 2, pos_a, ent_a);
  endfunction

  function automatic logic [32:0] exp_b();
    return model_vec(8, 2, 3, 3, 6, 1, 2, pos_b, ent_b);
  endfunction

  task automatic model_reset();
    pos_a = 800 * 525 - 1;
    ent_a = 0;
    pos_b = 16 * 10 - 1;
    ent_b = 0;
  endtask

  // One clk cycle of stimulus; the model advances only for enabled, out-of-reset cycles
  task automatic tick(input logic ea, input logic eb);
    pen_a = ea;
    pen_b = eb;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (ea) begin
        pos_a = (pos_a + 1) % (800 * 525);
        if (pos_a == 0) ent_a++;
      end
      if (eb) begin
        pos_b = (pos_b + 1) % (16 * 10);
        if (pos_b == 0) ent_b++;
      end
    end
  endtask

  task automatic test_reset();
    logic [32:0] rst_vec;
    int guard;
    rst_vec = {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    rst_n = 1'b0;
    model_reset();
    tick(0, 0);
    tick(0, 0);
    nvec++;
    if (va !== rst_vec) begin
      nfail++; $display("FAIL reset_a: got %h expected %h", va, rst_vec);
    end
    nvec++;
    if (vb !== exp_b()) begin
      nfail++; $display("FAIL reset_b: got %h expected %h", vb, exp_b());
    end
    rst_n = 1'b1;
    // Walk to (300,1) with random gating, then reset mid-line
    guard = 0;
    while (pos_a != 800 + 300 && guard < 5000) begin
      tick(1'($urandom_range(0, 1)), 0);
      guard++;
      nvec++;
      if (va !== exp_a()) begin
        nfail++; $display("FAIL walk_a: got %h expected %h", va, exp_a());
      end
    end
    nvec++;
    if (pos_a != 800 + 300) begin
      nfail++; $display("FAIL walk_a_timeout: got pos %0d required %0d", pos_a, 1100);
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if (va !== rst_vec) begin
      nfail++; $display("FAIL async_reset: got %h expected %h", va, rst_vec);
    end
    model_reset();
    tick(1, 1);
    nvec++;
    if (va !== exp_a()) begin
      nfail++; $display("FAIL reset_hold: got %h expected %h", va, exp_a());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_frame();
    logic [32:0] e0, e1;
    e0 = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
    e1 = {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tick(1, 0);
    nvec++;
    if (va !== e0) begin
      nfail++; $display("FAIL first_pixel: got %h expected %h", va, e0);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0);
      nvec++;
      if (va !== e0) begin
        nfail++; $display("FAIL first_pixel_hold: got %h expected %h", va, e0);
      end
    end
    tick(1, 0);
    nvec++;
    if (va !== e1) begin
      nfail++; $display("FAIL second_pixel: got %h expected %h", va, e1);
    end
  endtask

  task automatic test_hsync_timing();
    int hs_low, ls_high;
    hs_low  = 0;
    ls_high = 0;
    // Pixel strobe on every 2nd clk across two full lines
    for (int i = 0; i < 3200; i++) begin
      tick(1'(i % 2), 0);
      nvec++;
      if (va !== exp_a()) begin
        nfail++; $display("FAIL hline_a: got %h expected %h", va, exp_a());
      end
      if (!a_hs) hs_low++;
      if (a_ls) ls_high++;
    end
    nvec++;
    if (hs_low != 384) begin
      nfail++; $display("FAIL hsync_width: got %0d clk required %0d", hs_low, 384);
    end
    nvec++;
    if (ls_high != 4) begin
      nfail++; $display("FAIL line_start_width: got %0d clk required %0d", ls_high, 4);
    end
  endtask

  task automatic test_gating();
    logic [32:0] snap;
    int guard;
    guard = 0;
    while ((pos_a % 800) != 655 && guard < 4000) begin
      tick(1'($urandom_range(0, 1)), 0);
      guard++;
      nvec++;
      if (va !== exp_a()) begin
        nfail++; $display("FAIL seek_a: got %h expected %h", va, exp_a());
      end
    end
    nvec++;
    if ((pos_a % 800) != 655) begin
      nfail++; $display("FAIL seek_timeout: got x %0d required %0d", pos_a % 800, 655);
    end
    snap = va;
    for (int i = 0; i < 50; i++) begin
      tick(0, 0);
      nvec++;
      if (va !== snap) begin
        nfail++; $display("FAIL gated_hold: got %h expected %h", va, snap);
      end
    end
    tick(1, 0);
    nvec++;
    if ({a_x, a_hs} !== {10'd656, 1'b0}) begin
      nfail++; $display("FAIL hsync_entry: got x=%0d hs_n=%b required x=656 hs_n=0", a_x, a_hs);
    end
    nvec++;
    if (va !== exp_a()) begin
      nfail++; $display("FAIL reenable: got %h expected %h", va, exp_a());
    end
  endtask

  task automatic test_vertical();
    int vs_low, fs_high;
    vs_low  = 0;
    fs_high = 0;
    for (int i = 0; i < 160; i++) begin
      tick(0, 1);
      nvec++;
      if (vb !== exp_b()) begin
        nfail++; $display("FAIL vframe_b: got %h expected %h", vb, exp_b());
      end
      if (!b_vs) vs_low++;
      if (b_fs) fs_high++;
    end
    nvec++;
    if (vs_low != 32) begin
      nfail++; $display("FAIL vsync_width: got %0d pixels required %0d", vs_low, 32);
    end
    nvec++;
    if (fs_high != 1) begin
      nfail++; $display("FAIL frame_start_count: got %0d required %0d", fs_high, 1);
    end
    for (int i = 0; i < 400; i++) begin
      tick(0, 1'($urandom_range(0, 1)));
      nvec++;
      if (vb !== exp_b()) begin
        nfail++; $display("FAIL vrand_b: got %h expected %h", vb, exp_b());
      end
    end
  endtask

  task automatic test_frame_wrap();
    logic [7:0] prev;
    logic       en;
    int saw_wrap, guard, fs_seen;
    longint ent0;
    saw_wrap = 0;
    guard    = 0;
    fs_seen  = 0;
    ent0     = ent_b;
    prev     = b_cnt;
    while (saw_wrap == 0 && guard < 60000) begin
      en = ($urandom_range(0, 7) != 0);
      tick(0, en);
      guard++;
      nvec++;
      if (vb !== exp_b()) begin
        nfail++; $display("FAIL wrap_run_b: got %h expected %h", vb, exp_b());
      end
      if (en && b_fs) fs_seen++;
      if (prev == 8'd255 && b_cnt == 8'd0) saw_wrap = 1;
      prev = b_cnt;
    end
    nvec++;
    if (saw_wrap != 1) begin
      nfail++; $display("FAIL frame_cnt_wrap: got cnt %0d required 255->0 wrap", b_cnt);
    end
    nvec++;
    if (longint'(fs_seen) != ent_b - ent0) begin
      nfail++; $display("FAIL frame_start_rate: got %0d required %0d", fs_seen, ent_b - ent0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pen_a = 1'b0;
    pen_b = 1'b0;
    model_reset();
    test_reset();
    test_first_frame();
    test_hsync_timing();
    test_gating();
    test_vertical();
    test_frame_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
